// File: rtl/spi_master_multi.sv
// ==== spi_master_multi: N_SLAVES-chip-select SPI master, runtime CPOL/CPHA, rev 1.0 ====
// ==== Build option: define SPI_LSB_FIRST_EN for LSB-first shift order (MSB-first otherwise) ====
`default_nettype none

module spi_master_multi #(
  parameter int DATA_W   = 16,
  parameter int N_SLAVES = 3,
  parameter int CLK_DIV  = 2,
  localparam int SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [SEL_W-1:0]  slave_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [N_SLAVES-1:0] miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [N_SLAVES-1:0] cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rx_data_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int H_W   = BIT_W + 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(2 * DATA_W - 1);
  localparam logic [H_W-1:0]   BIT_LAST_H = H_W'(DATA_W - 1);
  localparam logic [SEL_W:0]   NSLV       = (SEL_W + 1)'(N_SLAVES);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [H_W-1:0]      h_q, h_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rxsh_q, rxsh_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [N_SLAVES-1:0] csn_q, csn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rx_q, rx_d;

  logic                w_sel_ok;
  logic                w_miso;
  logic                w_active;
  logic [H_W-1:0]      w_bit;
  logic [BIT_W-1:0]    w_phys;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    sel_d    = sel_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    tx_d     = tx_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    mosi_d   = mosi_q;
    err_d    = 1'b0;
    w_sel_ok = ({1'b0, slave_sel_i} < NSLV);
    w_miso   = miso_i[sel_q];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          if (w_sel_ok) begin
            state_d = S_SETUP;
            cnt_d   = '0;
            h_d     = '0;
            sel_d   = slave_sel_i;
            cpol_d  = cpol_i;
            cpha_d  = cpha_i;
            tx_d    = tx_data_i;
            rxsh_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
          h_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XFER: begin
        // Mid-bit sample: last clk of the half-period whose parity equals CPHA.
        if (cnt_q == CNT_LAST && h_q[0] == cpha_q) begin
`ifdef SPI_LSB_FIRST_EN
          rxsh_d = {w_miso, rxsh_q[DATA_W-1:1]};
`else
          rxsh_d = {rxsh_q[DATA_W-2:0], w_miso};
`endif
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (h_q == H_LAST) begin
            state_d = S_HOLD;
          end else begin
            h_d = h_q + H_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so they register in step with the FSM.
    w_active = (state_d == S_SETUP) || (state_d == S_XFER) || (state_d == S_HOLD);
    busy_d   = w_active;
    done_d   = (state_d == S_DONE);
    if (state_d == S_DONE) rx_d = rxsh_d;

    for (int j = 0; j < N_SLAVES; j++) begin
      csn_d[j] = !(w_active && (sel_d == SEL_W'(j)));
    end

    case (state_d)
      S_IDLE:  sclk_d = cpol_i;
      S_XFER:  sclk_d = h_d[0] ? cpol_d : ~cpol_d;
      default: sclk_d = cpol_d;
    endcase

    // Bit index on MOSI: CPHA=1 -> h/2, CPHA=0 -> ceil(h/2), clamped to the last bit.
    w_bit = {1'b0, h_d[H_W-1:1]} + (cpha_d ? H_W'(0) : {{(H_W-1){1'b0}}, h_d[0]});
    if (state_d == S_SETUP) w_bit = '0;
    if (w_bit > BIT_LAST_H) w_bit = BIT_LAST_H;
`ifdef SPI_LSB_FIRST_EN
    w_phys = w_bit[BIT_W-1:0];
`else
    w_phys = BIT_W'(DATA_W - 1) - w_bit[BIT_W-1:0];
`endif
    if (state_d == S_SETUP || state_d == S_XFER) mosi_d = tx_d[w_phys];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rxsh_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      sel_q   <= sel_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = csn_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rx_data_o = rx_q;

endmodule

`default_nettype wire

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised successor to the three-slave SPI master. It provides one SPI master engine serving N_SLAVES chip-selects, with configurable word width, a configurable SCLK divider and run-time selection of all four SPI modes (CPOL/CPHA). It returns a received-word strobe and sits between the system-side controller and the slave devices, replacing the fixed 16-bit, three-channel master.

## Interface
- DATA_W, 16: bits per transfer (≥2)
- N_SLAVES, 3: chip-select count (≥1); SEL_W = max(1, $clog2(N_SLAVES))
- CLK_DIV, 2: clk cycles per SCLK half-period (≥2)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request transfer; accepted only when busy=0
- slave_sel  in  SEL_W  target slave index, latched on accept
- cpol  in  1  clock polarity, latched on accept
- cpha  in  1  clock phase, latched on accept
- tx_data  in  DATA_W  word to send, latched on accept
- miso  in  N_SLAVES  per-slave MISO lines
- sclk  out  1  SPI clock
- mosi  out  1  shared MOSI
- cs_n  out  N_SLAVES  active-low chip-selects, one-hot-low when active
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, rx_data valid
- err  out  1  one-cycle pulse, start rejected for slave_sel ≥ N_SLAVES
- rx_data  out  DATA_W  last received word, held until next done

## Operation
- Reset values (rst=0 at a clk edge): state IDLE; sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, err=0, rx_data=0. Reset mid-transfer aborts immediately with no done pulse.
- FSM: IDLE → SETUP → XFER → HOLD → DONE → IDLE.
- IDLE: sclk tracks the cpol input, registered. A start with valid sel latches inputs and goes to SETUP. A start with sel ≥ N_SLAVES pulses err for 1 cycle and stays IDLE.
- SETUP (CLK_DIV cycles): cs_n[sel]=0, sclk=cpol, mosi=bit 0 of the shift order.
- XFER (2·DATA_W half-periods h=0..2·DATA_W−1, each CLK_DIV cycles):
  - sclk=~cpol for even h, cpol for odd h. The leading edge falls at the start of even h; the trailing edge falls at the start of odd h.
  - CPHA=0: bit i on mosi from h=2i−1 (bit 0 from SETUP). miso[sel] is sampled at h=2i.
  - CPHA=1: bit i on mosi from h=2i. Sampled at h=2i+1.
  - Sampling happens in the last clk cycle of the sampling half-period (mid-bit). Received bits shift in the same order as transmitted bits.
- HOLD (CLK_DIV cycles): sclk=cpol, cs_n[sel] still 0, mosi holds the last bit.
- DONE (1 cycle): cs_n all 1, busy=0, done=1, and rx_data is loaded from the shift register in this cycle. A start in this cycle is accepted as if in IDLE, giving back-to-back transfers.
- busy=1 from the cycle after accept through the last HOLD cycle.
- Inputs other than miso are ignored while busy=1. Unselected miso lines are ignored.
- Shift order is MSB-first by default; see Configuration.

## Timing
- Accept at edge 0. SETUP occupies cycles 1..CLK_DIV and XFER the next 2·DATA_W·CLK_DIV cycles. HOLD follows for CLK_DIV cycles. done is high in cycle CLK_DIV·(2·DATA_W+2)+1.
- Defaults: done in cycle 69. SCLK frequency = f_clk/(2·CLK_DIV).
- All outputs are registered; there is no combinational input→output path.
- err is high the cycle after a rejected start.
- Next-transfer accept is possible in the DONE cycle, giving a minimum spacing between done pulses of CLK_DIV·(2·DATA_W+2)+1 cycles.

## Configuration
- SPI_LSB_FIRST_EN
  - Defined: bit 0 of the shift order is tx_data[0], and received bits fill rx_data from bit 0 upward.
  - Undefined: bit 0 of the shift order is tx_data[DATA_W−1], and received bits fill from the MSB downward.
  - Cycle timing is identical in both builds.

## Test plan
- Mode 0, sel=0, tx=16'hA5C3, slave model returns 16'h3C5A → cs_n=3'b110 throughout, slave captures 16'hA5C3, rx_data=16'h3C5A with done in cycle 69, sclk idles 0.
- Mode 3, sel=2, tx=16'h0001, slave returns 16'hFFFE → cs_n=3'b011, sclk idles 1, rx_data=16'hFFFE, slave captures 16'h0001.
- Modes 1 and 2 on sel=1 with tx=16'h8000 → slave captures 16'h8000 in both; exactly 16 leading and 16 trailing edges.
- start with sel=3 (N_SLAVES=3) → err=1 for 1 cycle, cs_n stays 3'b111, busy stays 0.
- rst=0 at cycle 20 of a transfer → next cycle cs_n=3'b111, sclk=0, busy=0, no done; a new transfer then completes correctly.
- start held high through DONE with SPI_LSB_FIRST_EN defined and tx=16'h0003 → the second transfer begins in the DONE cycle, and the first two mosi bits of each word are 1,1.
